grayscale_frame_ctrl: RTL and testbench

- Frame-level sequencer between the camera pixel FIFO (24-bit RGB) and the grayscale datapath (FIFO-handshake, 1 pixel in -> 1 byte out, one pixel in flight max).
- On a start command it releases exactly width*height pixels into the datapath, tracks pixel position, and waits for all results to be written downstream.
- It then pulses done, or flushes cleanly on abort.
- Downstream Canny stages use done/pix_x/pix_y for frame alignment.

---
 rtl/grayscale_frame_ctrl.sv | 120 ++++++++++++
 tb/tb_grayscale_frame_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/grayscale_frame_ctrl.sv
// Frame sequencer between the RGB pixel FIFO and the grayscale datapath.
// Gates exactly width*height reads, tracks position, waits for drain.
module grayscale_frame_ctrl #(
  parameter int DIM_BITS  = 11,
  parameter int FCNT_BITS = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DIM_BITS-1:0]  cfg_width,
  input  logic [DIM_BITS-1:0]  cfg_height,
  input  logic                 src_empty,
  output logic                 src_rd_en,
  output logic                 dp_empty,
  input  logic                 dp_rd_en,
  input  logic                 dp_wr_en,
  output logic                 dp_full,
  input  logic                 snk_full,
  output logic                 snk_wr_en,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [DIM_BITS-1:0]  pix_x,
  output logic [DIM_BITS-1:0]  pix_y,
  output logic [FCNT_BITS-1:0] frame_count
);

  localparam int CB = 2 * DIM_BITS;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    FLUSH,
    FDONE
  } state_t;

  state_t state, nxt;

  logic [DIM_BITS-1:0] line_w;
  logic [CB-1:0]       total;
  logic [CB-1:0]       in_cnt;
  logic [CB-1:0]       out_cnt;
  logic                gate_open;
  logic                wr_acc;
  logic                accept;
  logic                last_rd;

  assign snk_wr_en = dp_wr_en;
  assign dp_full   = snk_full;
  assign gate_open = (state == RUN) && (in_cnt != total);
  assign dp_empty  = src_empty || !gate_open;
  assign src_rd_en = dp_rd_en && !dp_empty;
  assign wr_acc    = dp_wr_en && !snk_full && (state != IDLE);
  assign busy      = (state != IDLE);
  assign accept    = start && (cfg_width != '0) && (cfg_height != '0);
  assign last_rd   = src_rd_en && (in_cnt == total - CB'(1));

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (accept) nxt = RUN;
      RUN: begin
        if (abort)        nxt = FLUSH;
        else if (last_rd) nxt = DRAIN;
      end
      DRAIN: begin
        if (abort)                 nxt = FLUSH;
        else if (out_cnt == total) nxt = FDONE;
      end
      FLUSH: if (out_cnt == in_cnt) nxt = IDLE;
      FDONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      done        <= 1'b0;
      aborted     <= 1'b0;
      frame_count <= '0;
      line_w      <= '0;
      total       <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
    end else begin
      state   <= nxt;
      done    <= (nxt == FDONE);
      aborted <= (state == FLUSH) && (nxt == IDLE);
      if (nxt == FDONE)
        frame_count <= frame_count + FCNT_BITS'(1);
      if (state == IDLE && accept) begin
        line_w  <= cfg_width;
        total   <= CB'(cfg_width) * CB'(cfg_height);
        in_cnt  <= '0;
        out_cnt <= '0;
        pix_x   <= '0;
        pix_y   <= '0;
      end else begin
        if (src_rd_en) begin
          in_cnt <= in_cnt + CB'(1);
          // wrap on the last column; after the final read this leaves 0/height
          if (pix_x == line_w - DIM_BITS'(1)) begin
            pix_x <= '0;
            pix_y <= pix_y + DIM_BITS'(1);
          end else begin
            pix_x <= pix_x + DIM_BITS'(1);
          end
        end
        if (wr_acc)
          out_cnt <= out_cnt + CB'(1);
      end
    end
  end

endmodule

// File: tb/tb_grayscale_frame_ctrl.sv
// Bench for grayscale_frame_ctrl with a two-state grayscale datapath model.
// Table-driven frames plus hand sequences for abort, busy start and reset.
module tb_grayscale_frame_ctrl;

  localparam int DB = 11;
  localparam int FB = 16;

  logic          clock;
  logic          reset;
  logic          start;
  logic          abort;
  logic [DB-1:0] cfg_width;
  logic [DB-1:0] cfg_height;
  logic          src_empty;
  logic          src_rd_en;
  logic          dp_empty;
  logic          dp_rd_en;
  logic          dp_wr_en;
  logic          dp_full;
  logic          snk_full;
  logic          snk_wr_en;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [DB-1:0] pix_x;
  logic [DB-1:0] pix_y;
  logic [FB-1:0] frame_count;

  grayscale_frame_ctrl #(.DIM_BITS(DB), .FCNT_BITS(FB)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .src_empty(src_empty), .src_rd_en(src_rd_en),
    .dp_empty(dp_empty), .dp_rd_en(dp_rd_en), .dp_wr_en(dp_wr_en),
    .dp_full(dp_full), .snk_full(snk_full), .snk_wr_en(snk_wr_en),
    .busy(busy), .done(done), .aborted(aborted),
    .pix_x(pix_x), .pix_y(pix_y), .frame_count(frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // datapath: S0 reads one pixel, S1 writes one byte
  logic dps;
  assign dp_rd_en = !dps && !dp_empty;
  assign dp_wr_en = dps && !dp_full;
  always @(posedge clock or negedge reset) begin
    if (!reset) dps <= 1'b0;
    else if (dp_rd_en) dps <= 1'b1;
    else if (dp_wr_en) dps <= 1'b0;
  end

  int mode;
  int fcyc;
  always @(negedge clock) begin
    fcyc      <= busy ? fcyc + 1 : 0;
    src_empty <= (mode == 1) && ((fcyc / 3) % 2 == 1);
    snk_full  <= (mode == 1) && (fcyc >= 6) && (fcyc < 11);
  end

  int rd_cnt, wr_cnt, dn_cnt, ab_cnt, viol;
  int px[256];
  int py[256];
  initial begin
    rd_cnt = 0; wr_cnt = 0; dn_cnt = 0; ab_cnt = 0; viol = 0;
    fcyc = 0; src_empty = 1'b0; snk_full = 1'b0;
  end
  always @(posedge clock) begin
    if (src_rd_en) begin
      px[rd_cnt % 256] <= int'(pix_x);
      py[rd_cnt % 256] <= int'(pix_y);
      rd_cnt <= rd_cnt + 1;
      if (src_empty || dp_empty) viol <= viol + 1;
    end
    if (snk_wr_en && !snk_full) wr_cnt <= wr_cnt + 1;
    if (done) dn_cnt <= dn_cnt + 1;
    if (aborted) ab_cnt <= ab_cnt + 1;
  end

  int errs = 0;
  int nchk = 0;
  int exp_fc = 0;
  int b_rd, b_wr, b_dn, b_ab;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic snap();
    b_rd = rd_cnt; b_wr = wr_cnt; b_dn = dn_cnt; b_ab = ab_cnt;
  endtask

  task automatic kick(input int w, input int h, input bit ab);
    @(negedge clock);
    cfg_width = DB'(w); cfg_height = DB'(h);
    start = 1'b1; abort = ab;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_timeout_busy"}, int'(busy), 0);
    repeat (3) @(negedge clock);
  endtask

  typedef struct {
    int w;
    int h;
    int md;
    int exp_rd;
    int exp_dn;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{4, 2, 0, 8, 1};
    vt[1] = '{4, 2, 1, 8, 1};
    vt[2] = '{0, 3, 0, 0, 0};
    vt[3] = '{3, 0, 0, 0, 0};
    vt[4] = '{1, 1, 0, 1, 1};
    vt[5] = '{2, 3, 1, 6, 1};

    reset = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_width = '0; cfg_height = '0; mode = 0;
    repeat (3) @(negedge clock);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_fc", int'(frame_count), 0);
    chk("rst_pix_x", int'(pix_x), 0);
    chk("rst_pix_y", int'(pix_y), 0);
    chk("rst_dp_empty", int'(dp_empty), 1);
    chk("rst_src_rd_en", int'(src_rd_en), 0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      mode = vt[i].md;
      snap();
      kick(vt[i].w, vt[i].h, 1'b0);
      wait_idle($sformatf("v%0d", i));
      exp_fc += vt[i].exp_dn;
      chk($sformatf("v%0d_reads", i), rd_cnt - b_rd, vt[i].exp_rd);
      chk($sformatf("v%0d_writes", i), wr_cnt - b_wr, vt[i].exp_rd);
      chk($sformatf("v%0d_done", i), dn_cnt - b_dn, vt[i].exp_dn);
      chk($sformatf("v%0d_aborted", i), ab_cnt - b_ab, 0);
      chk($sformatf("v%0d_fc", i), int'(frame_count), exp_fc);
      for (int k = 0; k < vt[i].exp_rd; k++) begin
        chk($sformatf("v%0d_px%0d", i, k), px[(b_rd + k) % 256], k % vt[i].w);
        chk($sformatf("v%0d_py%0d", i, k), py[(b_rd + k) % 256], k / vt[i].w);
      end
      if (vt[i].exp_rd > 0) begin
        chk($sformatf("v%0d_end_x", i), int'(pix_x), 0);
        chk($sformatf("v%0d_end_y", i), int'(pix_y), vt[i].h);
      end
    end
    chk("no_read_when_empty", viol, 0);
    mode = 0;

    // abort after the 3rd accepted read
    snap();
    kick(4, 2, 1'b0);
    begin
      int n;
      n = 0;
      while ((rd_cnt - b_rd) < 3 && n < 200) begin
        @(negedge clock);
        n++;
      end
    end
    chk("ab_reads_before", rd_cnt - b_rd, 3);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    wait_idle("ab");
    chk("ab_reads", rd_cnt - b_rd, 3);
    chk("ab_writes", wr_cnt - b_wr, 3);
    chk("ab_aborted", ab_cnt - b_ab, 1);
    chk("ab_done", dn_cnt - b_dn, 0);
    chk("ab_fc", int'(frame_count), exp_fc);
    snap();
    kick(2, 2, 1'b0);
    wait_idle("ab_next");
    exp_fc++;
    chk("ab_next_reads", rd_cnt - b_rd, 4);
    chk("ab_next_done", dn_cnt - b_dn, 1);
    chk("ab_next_fc", int'(frame_count), exp_fc);

    // start while busy is dropped; first read one cycle after start
    snap();
    kick(2, 2, 1'b0);
    chk("lat_busy", int'(busy), 1);
    chk("lat_rd", int'(src_rd_en), 1);
    cfg_width = DB'(3); cfg_height = DB'(3); start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle("bs");
    repeat (5) @(negedge clock);
    exp_fc++;
    chk("bs_reads", rd_cnt - b_rd, 4);
    chk("bs_done", dn_cnt - b_dn, 1);
    chk("bs_idle", int'(busy), 0);

    // start and abort together in IDLE
    snap();
    kick(2, 1, 1'b1);
    wait_idle("sa");
    exp_fc++;
    chk("sa_reads", rd_cnt - b_rd, 2);
    chk("sa_done", dn_cnt - b_dn, 1);
    chk("sa_aborted", ab_cnt - b_ab, 0);
    chk("sa_fc", int'(frame_count), exp_fc);

    // reset mid-frame after 5 reads
    snap();
    kick(4, 4, 1'b0);
    begin
      int n;
      n = 0;
      while ((rd_cnt - b_rd) < 5 && n < 200) begin
        @(negedge clock);
        n++;
      end
    end
    chk("mr_reads_before", rd_cnt - b_rd, 5);
    reset = 1'b0;
    #1;
    chk("mr_busy", int'(busy), 0);
    chk("mr_dp_empty", int'(dp_empty), 1);
    chk("mr_pix_x", int'(pix_x), 0);
    chk("mr_pix_y", int'(pix_y), 0);
    chk("mr_fc", int'(frame_count), 0);
    @(negedge clock);
    reset = 1'b1;
    exp_fc = 0;
    snap();
    kick(4, 4, 1'b0);
    wait_idle("mr_next");
    exp_fc++;
    chk("mr_next_reads", rd_cnt - b_rd, 16);
    chk("mr_next_writes", wr_cnt - b_wr, 16);
    chk("mr_next_done", dn_cnt - b_dn, 1);
    chk("mr_next_fc", int'(frame_count), exp_fc);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
